// File: rtl/mips_pkg.sv
// Shared definitions for the data memory unit: access FSM state type and default sizing.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } dmem_state_e;

  localparam int unsigned DMEM_DEPTH_DEFAULT   = 256;
  localparam int unsigned DMEM_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with write enable and an enabled, clearable registered read.
module dmem_array
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read register only moves on a completed load or a clear, so it holds between loads.
  always_comb begin
    rdata_d = rdata_q;
    if (clr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory front end: stalls the pipeline for LATENCY cycles per load/store.
// Optional alignment checking is enabled with `define DMEM_ALIGN_CHECK_EN.
module data_mem_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter int unsigned LATENCY     = DMEM_LATENCY_DEFAULT
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e   state_d, state_q;
  logic [3:0]    count_d, count_q;
  logic [AW-1:0] idx_d, idx_q;
  logic [31:0]   wdata_d, wdata_q;
  logic          store_d, store_q;

  logic          req;
  logic          enter_done;
  logic          bad_access;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic          cur_store;
  logic          ram_we, ram_re, ram_clr;
  logic          unused_addr_bits;

  assign req = memread | memwrite;

  // With LATENCY == 1 the access completes straight out of IDLE, before anything is latched,
  // so the live request fields are used in IDLE and the latched copies afterwards.
  assign cur_idx   = (state_q == S_IDLE) ? address[AW+1:2] : idx_q;
  assign cur_wdata = (state_q == S_IDLE) ? writedata       : wdata_q;
  assign cur_store = (state_q == S_IDLE) ? memwrite        : store_q;

  assign enter_done = ((state_q == S_IDLE) && req && (LATENCY == 1)) ||
                      ((state_q == S_WAIT) && (count_q == 4'd1));

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] lo_d, lo_q;
  logic       misaligned_d, misaligned_q;
  logic [1:0] cur_lo;

  assign cur_lo       = (state_q == S_IDLE) ? address[1:0] : lo_q;
  assign bad_access   = (cur_lo != 2'b00);
  assign lo_d         = (state_q == S_IDLE && req) ? address[1:0] : lo_q;
  assign misaligned_d = !Reset && enter_done && bad_access;

  always_ff @(posedge clock) begin
    if (Reset) begin
      lo_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      lo_q         <= lo_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned = misaligned_q;
`else
  assign bad_access = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign unused_addr_bits = ^{address[31:AW+2], address[1:0]};

  assign ram_we  = !Reset && enter_done && cur_store && !bad_access;
  assign ram_re  = !Reset && enter_done && !cur_store && !bad_access;
  assign ram_clr = Reset || (enter_done && !cur_store && bad_access);

  assign stall = !Reset && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    store_d = store_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = address[AW+1:2];
          wdata_d = writedata;
          store_d = memwrite;
          count_d = LAT_M1;
          state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clock),
    .we   (ram_we),
    .re   (ram_re),
    .clr  (ram_clr),
    .addr (cur_idx),
    .wdata(cur_wdata),
    .rdata(readdata)
  );

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized self-checking bench for data_mem_unit against a word-array reference model.
module tb_data_mem_unit;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        Reset;
  logic        memread, memwrite;
  logic [31:0] address, writedata, readdata;
  logic        stall, misaligned;

  logic        b_memread, b_memwrite;
  logic [31:0] b_address, b_writedata, b_readdata;
  logic        b_stall, b_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl_mem   [256];
  bit          mdl_known [256];
  logic [31:0] mdl_rd;
  bit          mdl_rd_known;

  always #5 clock = ~clock;

  data_mem_unit #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clock(clock), .Reset(Reset), .memread(memread), .memwrite(memwrite),
    .address(address), .writedata(writedata), .readdata(readdata),
    .stall(stall), .misaligned(misaligned)
  );

  data_mem_unit #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clock(clock), .Reset(Reset), .memread(b_memread), .memwrite(b_memwrite),
    .address(b_address), .writedata(b_writedata), .readdata(b_readdata),
    .stall(b_stall), .misaligned(b_misaligned)
  );

  function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One complete access on the LATENCY=2 unit, checked against the model.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
    int cyc = 0;
    int idx = int'(a[9:2]);
    bit bad = is_bad(a);
    memread = rd; memwrite = wr; address = a; writedata = d;
    #1;
    while (stall === 1'b1 && cyc < 20) begin
      cyc++;
      @(posedge clock); #1;
    end
    if (wr) begin
      if (!bad) begin
        mdl_mem[idx] = d;
        mdl_known[idx] = 1'b1;
      end
    end else if (rd) begin
      if (bad) begin
        mdl_rd = '0; mdl_rd_known = 1'b1;
      end else begin
        mdl_rd = mdl_mem[idx]; mdl_rd_known = mdl_known[idx];
      end
    end
    n_checks++;
    if (cyc != LAT) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", tag, cyc, LAT);
    end
    if (mdl_rd_known) begin
      n_checks++;
      if (readdata !== mdl_rd) begin
        n_fail++;
        $display("FAIL %s readdata: got %h expected %h", tag, readdata, mdl_rd);
      end
    end
    n_checks++;
    if (misaligned !== bad) begin
      n_fail++;
      $display("FAIL %s misaligned_done: got %b expected %b", tag, misaligned, bad);
    end
    memread = 1'b0; memwrite = 1'b0;
    @(posedge clock); #1;
    n_checks++;
    if (stall !== 1'b0 || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: stall=%b misaligned=%b expected 0 0", tag, stall, misaligned);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    memread = 0; memwrite = 0; address = '0; writedata = '0;
    b_memread = 0; b_memwrite = 0; b_address = '0; b_writedata = '0;
    repeat (3) @(posedge clock);
    #1;
    Reset = 1'b0;
    mdl_rd = '0; mdl_rd_known = 1'b1;
    n_checks++;
    if (readdata !== 32'h0 || stall !== 1'b0 || misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rd=%h stall=%b mis=%b expected 0 0 0", readdata, stall, misaligned);
    end
    n_checks++;
    if (b_readdata !== 32'h0 || b_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_lat1: rd=%h stall=%b expected 0 0", b_readdata, b_stall);
    end
  endtask

  task automatic test_store_load();
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store_10");
    access(1'b1, 1'b0, 32'h10, 32'h0, "load_10");
    n_checks++;
    if (readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_10_value: got %h expected deadbeef", readdata);
    end
  endtask

  task automatic test_latency1();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      b_memwrite = (k == 0); b_memread = (k == 1);
      b_address = 32'h0; b_writedata = 32'h12345678;
      #1;
      while (b_stall === 1'b1 && cyc < 20) begin
        cyc++;
        @(posedge clock); #1;
      end
      n_checks++;
      if (cyc != 1) begin
        n_fail++;
        $display("FAIL lat1_stall_%0d: got %0d expected 1", k, cyc);
      end
      b_memread = 0; b_memwrite = 0;
      @(posedge clock); #1;
    end
    n_checks++;
    if (b_readdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL lat1_readdata: got %h expected 12345678", b_readdata);
    end
  endtask

  task automatic test_wrap();
    access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, "store_wrap");
    access(1'b1, 1'b0, 32'h0, 32'h0, "load_wrap");
    n_checks++;
    if (readdata !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL wrap_value: got %h expected a5a5a5a5", readdata);
    end
  endtask

  task automatic test_reset_mid_access();
    access(1'b0, 1'b1, 32'h20, 32'h5A5A0000, "prior_20");
    memwrite = 1'b1; address = 32'h20; writedata = 32'h11111111;
    @(posedge clock); #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_wait_stall: got %b expected 1", stall);
    end
    Reset = 1'b1; memwrite = 1'b0;
    @(posedge clock); #1;
    Reset = 1'b0;
    #1;
    mdl_rd = '0; mdl_rd_known = 1'b1;
    n_checks++;
    if (stall !== 1'b0 || readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state: stall=%b rd=%h expected 0 0", stall, readdata);
    end
    @(posedge clock); #1;
    access(1'b1, 1'b0, 32'h20, 32'h0, "load_after_abort");
    n_checks++;
    if (readdata !== 32'h5A5A0000) begin
      n_fail++;
      $display("FAIL abort_no_commit: got %h expected 5a5a0000", readdata);
    end
  endtask

  task automatic test_misaligned();
    access(1'b0, 1'b1, 32'h22, 32'h77777777, "store_22");
    access(1'b1, 1'b0, 32'h20, 32'h0, "load_20");
    access(1'b1, 1'b0, 32'h21, 32'h0, "load_21");
  endtask

  task automatic test_both_high();
    access(1'b1, 1'b0, 32'h10, 32'h0, "pre_both");
    access(1'b1, 1'b1, 32'h8, 32'h0000CAFE, "both_high");
    n_checks++;
    if (readdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL both_high_rd_held: got %h expected deadbeef", readdata);
    end
    access(1'b1, 1'b0, 32'h8, 32'h0, "load_8");
    n_checks++;
    if (readdata !== 32'h0000CAFE) begin
      n_fail++;
      $display("FAIL both_high_commit: got %h expected 0000cafe", readdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int kind;
    for (int w = 0; w < 8; w++) begin
      access(1'b0, 1'b1, 32'(w * 4), $urandom, "seed_store");
    end
    for (int i = 0; i < 60; i++) begin
      a = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      kind = int'($urandom_range(0, 2));
      access(kind != 1, kind != 0, a, $urandom, "random");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
        n_checks++;
        if (stall !== 1'b0 || (mdl_rd_known && readdata !== mdl_rd)) begin
          n_fail++;
          $display("FAIL idle_hold: stall=%b rd=%h expected 0 %h", stall, readdata, mdl_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_latency1();
    test_wrap();
    test_reset_mid_access();
    test_misaligned();
    test_both_high();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the array (power of two).
REQ-002 Parameter LATENCY, default 2, access latency in cycles (legal range 1..15).
REQ-003 Ports clock and Reset: one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock shared with PC and Regfile.
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 memread  input  1  load request from control.
REQ-007 memwrite  input  1  store request from control.
REQ-008 address  input  32  byte address (ALU result).
REQ-009 writedata  input  32  store data (register file read port 2).
REQ-010 readdata  output  32  load result to the write-back mux.
REQ-011 stall  output  1  freezes PC and register write while high.
REQ-012 misaligned  output  1  one-cycle flag for an access with address[1:0] != 0.

Function
REQ-013 FSM states IDLE, WAIT, DONE; count is a 4-bit down-counter.
REQ-014 IDLE with memread or memwrite high: latch address, writedata and kind; count <= LATENCY-1; next state WAIT, or DONE if LATENCY == 1.
REQ-015 WAIT: count decrements each cycle; at count == 1 go DONE.
REQ-016 DONE: unconditionally return to IDLE next cycle; requests seen in DONE are ignored (same instruction).
REQ-017 stall = (IDLE and (memread or memwrite)) or WAIT; stall is combinational and low in DONE; total stall = LATENCY cycles per access.
REQ-018 Word index = latched address[log2(DEPTH_WORDS)+1:2]; upper bits are ignored (address wraps modulo array size).
REQ-019 Store commits to the array on the clock edge entering DONE; there are no partial or byte writes.
REQ-020 Load: readdata registered on the clock edge entering DONE; held until the next completed load or Reset.
REQ-021 memread and memwrite both high: treat as a store; readdata is unchanged.
REQ-022 No request in IDLE: no state change, stall 0, readdata held.

Reset
REQ-023 Reset forces state IDLE, count 0, readdata 0, stall 0, misaligned 0.
REQ-024 Reset mid-access (WAIT) aborts the access; a pending store is never committed.
REQ-025 Array contents are not cleared by Reset.

Configuration
REQ-026 Macro DMEM_ALIGN_CHECK_EN defined: address[1:0] != 0 at acceptance pulses misaligned in DONE, suppresses the store, and loads 0 into readdata.
REQ-027 Macro DMEM_ALIGN_CHECK_EN undefined: address[1:0] ignored; misaligned tied to 0.

Structure
REQ-028 Shared package mips_pkg holds the FSM state typedef, DMEM_DEPTH_DEFAULT (256) and DMEM_LATENCY_DEFAULT (2).
REQ-029 Sub-module dmem_array: single-port synchronous RAM with a write enable and a registered read.

Verification (LATENCY=2, DEPTH_WORDS=256)
REQ-030 Store 0xDEADBEEF to 0x10, then load 0x10 -> stall high 2 cycles each; readdata = 0xDEADBEEF in DONE.
REQ-031 LATENCY=1, load from 0x0 preloaded with 0x12345678 -> stall high exactly 1 cycle; readdata = 0x12345678.
REQ-032 Store 0xA5A5A5A5 to 0x400 (wraps to word 0), load 0x0 -> readdata = 0xA5A5A5A5.
REQ-033 Store 0x11111111 to 0x20, Reset asserted in WAIT -> IDLE, stall 0, readdata 0; a later load of 0x20 returns the prior contents.
REQ-034 DMEM_ALIGN_CHECK_EN, store to 0x22 -> misaligned pulses 1 cycle; word 0x20 unchanged; load 0x21 -> readdata 0.
REQ-035 memread and memwrite both high, 0x0000CAFE to 0x8 -> store committed; readdata unchanged; a following load of 0x8 returns 0x0000CAFE.
